// File: rtl/nec_uart_formatter.sv
// NEC event to ASCII line formatter feeding a UART TX over its valid/done handshake.
// One line is in flight (active slot) while a single further event may wait (pending slot).
module nec_uart_formatter #(
  parameter bit CHECK_INV = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_valid,
  input  logic [31:0] i_frame,
  input  logic        i_repeat,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic [1:0] {
    EV_GOOD = 2'd0,
    EV_BAD  = 2'd1,
    EV_REP  = 2'd2
  } ev_kind_e;

  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] addr;
    logic [7:0] cmd;
  } event_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [2:0] line_len(input ev_kind_e kind);
    case (kind)
      EV_GOOD: return 3'd7;
      EV_BAD:  return 3'd5;
      default: return 3'd3;
    endcase
  endfunction

  function automatic logic [7:0] line_byte(input event_t ev, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (ev.kind)
      EV_GOOD: begin
        case (idx)
          3'd0:    b = hex_ascii(ev.addr[7:4]);
          3'd1:    b = hex_ascii(ev.addr[3:0]);
          3'd2:    b = 8'h20;
          3'd3:    b = hex_ascii(ev.cmd[7:4]);
          3'd4:    b = hex_ascii(ev.cmd[3:0]);
          3'd5:    b = 8'h0D;
          3'd6:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
      EV_BAD: begin
        case (idx)
          3'd0:    b = 8'h45;
          3'd1:    b = 8'h52;
          3'd2:    b = 8'h52;
          3'd3:    b = 8'h0D;
          3'd4:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
      default: begin
        case (idx)
          3'd0:    b = 8'h52;
          3'd1:    b = 8'h0D;
          3'd2:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
    endcase
    return b;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  event_t     active_q, active_d;
  event_t     pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       new_event;
  logic       inv_ok;
  event_t     cap_ev;
  logic       last_byte;
  logic       done_last;
  logic       captured;
  logic       drop_full;
  logic [1:0] drop_inc;

  assign new_event = i_frame_valid | i_repeat;
  assign inv_ok    = ((i_frame[7:0] ^ i_frame[15:8]) == 8'hFF) &&
                     ((i_frame[23:16] ^ i_frame[31:24]) == 8'hFF);
  assign last_byte = (idx_q == (line_len(active_q.kind) - 3'd1));
  assign done_last = (state_q == S_WAIT) && i_tx_done && last_byte;

  // A frame wins over a coincident repeat; classification is frozen here.
  always_comb begin
    cap_ev = '0;
    if (i_frame_valid) begin
      cap_ev.kind = (CHECK_INV && !inv_ok) ? EV_BAD : EV_GOOD;
      cap_ev.addr = i_frame[7:0];
      cap_ev.cmd  = i_frame[23:16];
    end else begin
      cap_ev.kind = EV_REP;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tx_data_d    = tx_data_q;
    captured     = 1'b0;
    drop_full    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (new_event) begin
          active_d = cap_ev;
          idx_d    = 3'd0;
          state_d  = S_SEND;
          captured = 1'b1;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (i_tx_done && !last_byte) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_SEND;
        end else if (done_last) begin
          idx_d = 3'd0;
          if (pend_valid_q) begin
            active_d     = pend_q;
            state_d      = S_SEND;
            pend_valid_d = new_event;
            if (new_event) begin
              pend_d   = cap_ev;
              captured = 1'b1;
            end
          end else if (new_event) begin
            // Slot frees this very cycle, so the event starts its line directly.
            active_d = cap_ev;
            state_d  = S_SEND;
            captured = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && !done_last && new_event) begin
      if (!pend_valid_q) begin
        pend_d       = cap_ev;
        pend_valid_d = 1'b1;
        captured     = 1'b1;
      end else begin
        drop_full = 1'b1;
      end
    end

    if (state_d == S_SEND) begin
      tx_data_d = line_byte(active_d, idx_d);
    end
  end

  assign drop_inc   = {1'b0, i_frame_valid & i_repeat} + {1'b0, drop_full};
  assign drop_cnt_d = sat_add(drop_cnt_q, drop_inc);
  assign err_cnt_d  = sat_add(err_cnt_q, {1'b0, captured && (cap_ev.kind == EV_BAD)});

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the two event slots are plain registers, so they are reset along with the FSM.
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      tx_data_q    <= 8'h00;
      drop_cnt_q   <= 8'h00;
      err_cnt_q    <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tx_data_q    <= tx_data_d;
      drop_cnt_q   <= drop_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_tx_valid = (state_q == S_SEND);
  assign o_tx_data  = tx_data_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_drop_cnt = drop_cnt_q;
  assign o_err_cnt  = err_cnt_q;

endmodule
